// File: rtl/add_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : add_pipe
// Brief    : Elastic pipelined add/sub/accumulate stage with wrap or saturate.
//            Define ADD_PIPE_STATS_EN to add beat_count / ovf_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module add_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
`ifdef ADD_PIPE_STATS_EN
    output logic             ovf,
    output logic [15:0]      beat_count,
    output logic [15:0]      ovf_count
`else
    output logic             ovf
`endif
);

    localparam logic [1:0] c_MODE_ADD = 2'b00;
    localparam logic [1:0] c_MODE_SUB = 2'b01;
    localparam logic [1:0] c_MODE_ACC = 2'b10;
    localparam logic [1:0] c_MODE_CLR = 2'b11;
    localparam int         c_MSB      = WIDTH - 1;

    logic             w_advance;
    logic             w_accept;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_sub;
    logic [WIDTH-1:0] w_raw;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sat_val;
    logic [WIDTH-1:0] w_res;
    logic             w_res_ovf;

    logic [WIDTH-1:0] r_acc;
    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_c   [STAGES];
    logic             r_ovf [STAGES];

    assign w_advance = !out_valid || out_ready;
    assign w_accept  = in_valid && w_advance;
    assign in_ready  = w_advance;

    // ACC reuses the adder with the accumulator as the first operand.
    always_comb begin
        w_x   = (mode == c_MODE_ACC) ? r_acc : a;
        w_y   = (mode == c_MODE_ACC) ? a : b;
        w_sub = (mode == c_MODE_SUB);
    end

    generate
        if (SIGNED) begin : g_signed
            always_comb begin
                w_raw     = w_sub ? (w_x - w_y) : (w_x + w_y);
                w_ovf     = (w_sub ? (w_x[c_MSB] != w_y[c_MSB]) : (w_x[c_MSB] == w_y[c_MSB]))
                            && (w_raw[c_MSB] != w_x[c_MSB]);
                w_sat_val = w_x[c_MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin : g_unsigned
            logic [WIDTH:0] w_ext;
            always_comb begin
                w_ext     = w_sub ? ({1'b0, w_x} - {1'b0, w_y}) : ({1'b0, w_x} + {1'b0, w_y});
                w_raw     = w_ext[WIDTH-1:0];
                w_ovf     = w_ext[WIDTH];
                w_sat_val = w_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
            end
        end
    endgenerate

    always_comb begin
        w_res     = (sat && w_ovf) ? w_sat_val : w_raw;
        w_res_ovf = w_ovf;
        if (mode == c_MODE_CLR) begin
            w_res     = '0;
            w_res_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_accept && (mode == c_MODE_ACC || mode == c_MODE_CLR)) begin
            r_acc <= w_res;
        end
    end

    // Every stage moves together on w_advance; bubbles travel like beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i] <= 1'b0;
                r_c[i]   <= '0;
                r_ovf[i] <= 1'b0;
            end
        end else if (w_advance) begin
            r_vld[0] <= in_valid;
            r_c[0]   <= w_res;
            r_ovf[0] <= w_res_ovf;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_c[i]   <= r_c[i-1];
                r_ovf[i] <= r_ovf[i-1];
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign c         = r_c[STAGES-1];
    assign ovf       = r_ovf[STAGES-1];

`ifdef ADD_PIPE_STATS_EN
    logic [15:0] r_beat_cnt;
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_accept && r_beat_cnt != 16'hFFFF) begin
                r_beat_cnt <= r_beat_cnt + 16'd1;
            end
            if (out_valid && out_ready && ovf && r_ovf_cnt != 16'hFFFF) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    assign beat_count = r_beat_cnt;
    assign ovf_count  = r_ovf_cnt;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_add_pipe
// Brief    : Scoreboard bench for add_pipe (unsigned and signed instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_pipe;

    localparam int         ST    = 2;
    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_SUB = 2'b01;
    localparam logic [1:0] M_ACC = 2'b10;
    localparam logic [1:0] M_CLR = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid_u = 1'b0;
    logic       in_valid_s = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [1:0] mode = '0;
    logic       sat = 1'b0;

    logic       in_ready_u, out_valid_u, ovf_u;
    logic       in_ready_s, out_valid_s, ovf_s;
    logic [7:0] c_u, c_s;
`ifdef ADD_PIPE_STATS_EN
    logic [15:0] beat_count_u, ovf_count_u, beat_count_s, ovf_count_s;
`endif

    add_pipe #(.WIDTH(8), .STAGES(ST), .SIGNED(1'b0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid_u), .in_ready(in_ready_u),
        .a(a), .b(b), .mode(mode), .sat(sat), .out_valid(out_valid_u),
        .out_ready(out_ready), .c(c_u),
`ifdef ADD_PIPE_STATS_EN
        .ovf(ovf_u), .beat_count(beat_count_u), .ovf_count(ovf_count_u)
`else
        .ovf(ovf_u)
`endif
    );

    add_pipe #(.WIDTH(8), .STAGES(ST), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .a(a), .b(b), .mode(mode), .sat(sat), .out_valid(out_valid_s),
        .out_ready(out_ready), .c(c_s),
`ifdef ADD_PIPE_STATS_EN
        .ovf(ovf_s), .beat_count(beat_count_s), .ovf_count(ovf_count_s)
`else
        .ovf(ovf_s)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] c;
        logic       ovf;
        int         at;
        string      nm;
    } exp_t;

    exp_t q_u[$];
    exp_t q_s[$];
    exp_t e_u, e_s;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid_u && out_ready) begin
            if (q_u.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_u: got c=%0h, required no output", c_u);
            end else begin
                e_u = q_u.pop_front();
                chk({e_u.nm, "_c"}, {24'd0, c_u}, {24'd0, e_u.c});
                chk({e_u.nm, "_ovf"}, {31'd0, ovf_u}, {31'd0, e_u.ovf});
                if (e_u.at >= 0) chk({e_u.nm, "_latency"}, cyc, e_u.at);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid_s && out_ready) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_s: got c=%0h, required no output", c_s);
            end else begin
                e_s = q_s.pop_front();
                chk({e_s.nm, "_c"}, {24'd0, c_s}, {24'd0, e_s.c});
                chk({e_s.nm, "_ovf"}, {31'd0, ovf_s}, {31'd0, e_s.ovf});
                if (e_s.at >= 0) chk({e_s.nm, "_latency"}, cyc, e_s.at);
            end
        end
    end

    // Presents one beat, pushes its expectation on the accepting cycle.
    task automatic send(input bit s, input logic [1:0] m, input logic [7:0] av,
                        input logic [7:0] bv, input bit st, input bit push,
                        input logic [7:0] ec, input bit eo, input bit lat, input string nm);
        exp_t e;
        int   n = 0;
        bit   done = 1'b0;
        a = av; b = bv; mode = m; sat = st;
        if (s) in_valid_s = 1'b1;
        else   in_valid_u = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (s ? in_ready_s : in_ready_u) begin
                if (push) begin
                    e.c = ec; e.ovf = eo; e.at = lat ? cyc + ST : -1; e.nm = nm;
                    if (s) q_s.push_back(e);
                    else   q_u.push_back(e);
                end
                done = 1'b1;
            end else if (++n > 50) begin
                checks++;
                errors++;
                $display("FAIL %s_accept_timeout: got in_ready=0, required 1", nm);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        in_valid_u = 1'b0;
        in_valid_s = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_u.size() + q_s.size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", q_u.size() + q_s.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid_u}, 0);
        chk("rst_in_ready", {31'd0, in_ready_u}, 1);
        chk("rst_c", {24'd0, c_u}, 0);
        chk("rst_ovf", {31'd0, ovf_u}, 0);
        chk("rst_out_valid_s", {31'd0, out_valid_s}, 0);
        @(posedge clk);
        #1;

        send(0, M_ADD, 8'd4,   8'd7,   0, 1, 8'd11,  0, 1, "add_4_7");
        send(0, M_ADD, 8'd8,   8'd12,  0, 1, 8'd20,  0, 1, "add_8_12");
        send(0, M_ADD, 8'd200, 8'd100, 0, 1, 8'd44,  1, 0, "add_wrap");
        send(0, M_ADD, 8'd200, 8'd100, 1, 1, 8'd255, 1, 0, "add_sat");
        send(0, M_SUB, 8'd3,   8'd5,   1, 1, 8'd0,   1, 0, "sub_sat");
        send(0, M_SUB, 8'd3,   8'd5,   0, 1, 8'd254, 1, 0, "sub_wrap");
        send(0, M_SUB, 8'd9,   8'd4,   0, 1, 8'd5,   0, 0, "sub_9_4");
        send(0, M_CLR, 8'd9,   8'd9,   0, 1, 8'd0,   0, 0, "clr");
        send(0, M_ACC, 8'd10,  8'd99,  0, 1, 8'd10,  0, 0, "acc_10");
        send(0, M_ACC, 8'd20,  8'd99,  0, 1, 8'd30,  0, 0, "acc_20");
        send(0, M_ACC, 8'd30,  8'd99,  0, 1, 8'd60,  0, 0, "acc_30");
        send(0, M_ADD, 8'd1,   8'd1,   0, 1, 8'd2,   0, 0, "add_1_1");
        send(0, M_ACC, 8'd5,   8'd0,   0, 1, 8'd65,  0, 0, "acc_5");
        send(0, M_ACC, 8'd200, 8'd0,   1, 1, 8'd255, 1, 0, "acc_sat");
        send(0, M_CLR, 8'd0,   8'd0,   0, 1, 8'd0,   0, 0, "clr2");
        idle();

        send(1, M_ADD, 8'd100, 8'd50,  1, 1, 8'h7F, 1, 1, "s_add_sat");
        send(1, M_ADD, 8'd100, 8'd50,  0, 1, 8'h96, 1, 0, "s_add_wrap");
        send(1, M_SUB, 8'h9C,  8'd50,  1, 1, 8'h80, 1, 0, "s_sub_sat");
        send(1, M_ADD, 8'hFD,  8'd5,   0, 1, 8'd2,  0, 0, "s_add_m3_5");
        idle();
        drain();

        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    logic [7:0] v;
                    v = i[7:0];
                    send(0, M_ADD, v, 8'd0, 0, 1, v, 0, 0, "stall_seq");
                end
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                chk("stall_in_ready", {31'd0, in_ready_u}, 0);
                chk("stall_out_valid", {31'd0, out_valid_u}, 1);
                chk("stall_c_hold", {24'd0, c_u}, 1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(0, M_ACC, 8'd3, 8'd0, 0, 0, 8'd0, 0, 0, "inflight");
        send(0, M_ACC, 8'd3, 8'd0, 0, 0, 8'd0, 0, 0, "inflight");
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid_u}, 0);
        chk("midrst_c", {24'd0, c_u}, 0);
`ifdef ADD_PIPE_STATS_EN
        chk("midrst_beat_count", {16'd0, beat_count_u}, 0);
        chk("midrst_ovf_count", {16'd0, ovf_count_u}, 0);
`endif
        @(posedge clk);
        #1;
        send(0, M_ACC, 8'd7, 8'd0, 0, 1, 8'd7, 0, 0, "acc_after_rst");
        idle();
        drain();
        repeat (6) @(posedge clk);
        #1;
`ifdef ADD_PIPE_STATS_EN
        chk("beat_count_after", {16'd0, beat_count_u}, 1);
`endif
        chk("final_queue", q_u.size() + q_s.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined, multi-mode adder. Successor to the team's single-cycle registered 8-bit adder.
- Generalised in operand width, pipeline depth and signedness; adds subtract and accumulate modes, wrap/saturate selection, overflow flag and valid/ready flow control.
- Sits between datapath producers and consumers as an elastic arithmetic stage.

Parameters:
- WIDTH, 8, operand/result width in bits (2..32).
- STAGES, 2, pipeline depth = result latency in cycles (1..4).
- SIGNED, 0, 0 = unsigned arithmetic, 1 = two's-complement arithmetic.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- mode  in  2  00 ADD a+b; 01 SUB a-b; 10 ACC acc+a; 11 CLR (acc<=0, result 0).
- sat  in  1  1 = saturate on overflow, 0 = wrap.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- c  out  WIDTH  result.
- ovf  out  1  overflow/underflow occurred for this result (set even when saturated).

Behaviour:
- Reset, synchronous, active-high, clock clk: all stage valid bits 0, out_valid 0, c 0, ovf 0, accumulator 0. Reset mid-stream drops all in-flight beats; no output appears for them.
- Pipeline: STAGES registered stages with a global advance signal. advance = !out_valid || out_ready. in_ready = advance (combinational, no dependency on in_valid).
- A beat accepted at edge N appears on c/out_valid after edge N+STAGES-1 when unstalled, i.e. it is visible in the cycle after STAGES edges from acceptance. STAGES=1 matches the old registered adder latency.
- Stall: while out_valid && !out_ready, c, ovf and out_valid hold stable and no stage advances. Bubbles are not compressed.
- Arithmetic is computed at acceptance in the first stage; later stages only delay.
  - Unsigned ADD: WIDTH+1 sum; ovf = carry-out; saturate value = all ones.
  - Unsigned SUB: ovf = borrow; saturate value = 0.
  - Signed: ovf = operands of like sign (ADD) or unlike sign (SUB) giving a result of differing sign; saturate to max positive or min negative according to the operand-A sign.
  - With sat=0, c = low WIDTH bits.
- ACC: acc <= result of acc+a (same sat/wrap rule, b ignored); c = new acc value. The accumulator updates only on an accepted beat, so back-to-back ACC beats chain correctly with no hazard.
- CLR: acc <= 0; c = 0; ovf = 0.
- ADD/SUB do not modify acc.
- in_valid with !in_ready: the beat is not taken; the producer must hold a, b, mode and sat stable.
- Simultaneous accept and output in the same cycle is supported (full throughput, 1 beat/cycle).

Optional Feature:
- ADD_PIPE_STATS_EN defined: adds outputs beat_count[15:0] (accepted beats) and ovf_count[15:0] (output beats with ovf=1, counted on out_valid && out_ready).
  - Both counters saturate at 16'hFFFF and clear on reset.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- WIDTH=8, STAGES=2, unsigned, out_ready=1: ADD a=4, b=7 -> c=11, ovf=0, out_valid exactly 2 cycles after acceptance. Then a=8, b=12 -> c=20 the next cycle.
- Unsigned ADD a=200, b=100: sat=0 -> c=44, ovf=1; sat=1 -> c=255, ovf=1. SUB a=3, b=5 with sat=1 -> c=0, ovf=1.
- SIGNED=1: ADD 100+50, sat=1 -> c=127, ovf=1. SUB -100-50, sat=1 -> c=-128, ovf=1. ADD -3+5 -> c=2, ovf=0.
- CLR, then ACC a=10, 20, 30 on consecutive cycles -> c=10, 30, 60. Then ADD 1+1 -> c=2 with acc unchanged; next ACC a=5 -> c=65.
- Hold out_ready=0 for 4 cycles with in_valid=1: in_ready drops once the pipeline fills, c holds stable, no beats are lost or duplicated. The sequence 1..6 is received in order once out_ready=1.
- Assert reset with 2 beats in flight -> out_valid=0 the next cycle, acc=0, those beats never emerge. With ADD_PIPE_STATS_EN defined, beat_count=0 and ovf_count=0 after reset.
